// File: rtl/dlx_mem_pkg.sv
// Shared encodings, FSM state type and lane helpers for the DLX memory arbiter.
package dlx_mem_pkg;

   localparam int unsigned DLX_DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DREAD,
      ST_DWRITE,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_DONE
   } state_e;

   // Attributes of the granted request, latched in IDLE.
   typedef struct packed {
      logic       is_data;
      logic       we;
      logic [1:0] size;
      logic       sgn;
      logic       err;
   } req_t;

   // Big-endian byte lane k lives at bits [31-8k:24-8k].
   function automatic logic [7:0] get_byte(logic [31:0] word, logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   // Halfword lane is selected by addr[1] only.
   function automatic logic [15:0] get_half(logic [31:0] word, logic lane);
      return lane ? word[15:0] : word[31:16];
   endfunction

   function automatic logic access_err(logic [1:0] size, logic [1:0] addr_lo);
      logic e;
      case (size)
         SZ_BYTE: e = 1'b0;
         SZ_HALF: e = addr_lo[0];
         SZ_WORD: e = (addr_lo != 2'b00);
         default: e = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: RMW merge of store data and load extraction/extension.
module mem_lane_align
   import dlx_mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        sgn_i,
   output logic [31:0] merged_o,
   output logic [31:0] extracted_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Load path: pick the lane, then zero- or sign-extend from its MSB.
   always_comb begin
      byte_sel = get_byte(word_i, addr_lo_i);
      half_sel = get_half(word_i, addr_lo_i[1]);
      case (size_i)
         SZ_BYTE: extracted_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: extracted_o = {{16{sgn_i & half_sel[15]}}, half_sel};
         default: extracted_o = word_i;
      endcase
   end

   // Store path: replace only the addressed lane of the word just read.
   always_comb begin
      merged_o = word_i;
      case (size_i)
         SZ_BYTE: begin
            case (addr_lo_i)
               2'd0:    merged_o[31:24] = wdata_i[7:0];
               2'd1:    merged_o[23:16] = wdata_i[7:0];
               2'd2:    merged_o[15:8]  = wdata_i[7:0];
               default: merged_o[7:0]   = wdata_i[7:0];
            endcase
         end
         SZ_HALF: begin
            if (addr_lo_i[1]) merged_o[15:0]  = wdata_i[15:0];
            else              merged_o[31:16] = wdata_i[15:0];
         end
         SZ_WORD: merged_o = wdata_i;
         default: merged_o = word_i;
      endcase
   end

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates the single-port sram between DLX fetch and memory stages;
// sub-word stores are sequenced as read-modify-write.
module dlx_mem_arbiter
   import dlx_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ready_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [1:0]        d_size_i,
   input  logic              d_signed_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ready_o,
   output logic              d_err_o,
   output logic              mem_cs_o,
   output logic              mem_oe_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_din_o,
   input  logic [DATA_W-1:0] mem_dout_i
);

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              mem_cs_d, mem_oe_d, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_din_d;
   logic [DATA_W-1:0] d_rdata_d, if_rdata_d;
   logic              d_ready_d, if_ready_d, d_err_d;

   logic [DATA_W-1:0] merged, extracted;

   mem_lane_align u_lane (
      .word_i      (mem_dout_i),
      .wdata_i     (wdata_q),
      .size_i      (req_q.size),
      .addr_lo_i   (addr_q[1:0]),
      .sgn_i       (req_q.sgn),
      .merged_o    (merged),
      .extracted_o (extracted)
   );

   // State and latched request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state and grant: data requests always win over fetch.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (d_req_i) begin
               req_d.is_data = 1'b1;
               req_d.we      = d_we_i;
               req_d.size    = d_size_i;
               req_d.sgn     = d_signed_i;
               req_d.err     = access_err(d_size_i, d_addr_i[1:0]);
               addr_d        = d_addr_i;
               wdata_d       = d_wdata_i;
               if (req_d.err)              state_d = ST_DONE;
               else if (!d_we_i)           state_d = ST_DREAD;
               else if (d_size_i == SZ_WORD) state_d = ST_DWRITE;
               else                        state_d = ST_RMW_RD;
            end else if (if_req_i) begin
               req_d   = '{is_data: 1'b0, we: 1'b0, size: SZ_WORD, sgn: 1'b0, err: 1'b0};
               addr_d  = if_addr_i;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH, ST_DREAD, ST_DWRITE: state_d = ST_DONE;
         ST_RMW_RD:                     state_d = ST_RMW_WR;
         ST_RMW_WR:                     state_d = ST_DONE;
         ST_DONE:                       state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state and latched request only.
   always_comb begin
      mem_cs_d   = 1'b0;
      mem_oe_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = '0;
      mem_din_d  = '0;
      d_ready_d  = 1'b0;
      if_ready_d = 1'b0;
      d_err_d    = 1'b0;
      d_rdata_d  = d_rdata_o;
      if_rdata_d = if_rdata_o;
      case (state_d)
         ST_FETCH, ST_DREAD, ST_RMW_RD: begin
            mem_cs_d   = 1'b1;
            mem_oe_d   = 1'b1;
            mem_addr_d = addr_d & ~ADDR_W'(3);
         end
         ST_DWRITE: begin
            mem_cs_d   = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = addr_d & ~ADDR_W'(3);
            mem_din_d  = wdata_d;
         end
         ST_RMW_WR: begin
            mem_cs_d   = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = addr_d & ~ADDR_W'(3);
            mem_din_d  = merged;
         end
         ST_DONE: begin
            d_ready_d  = req_d.is_data;
            if_ready_d = !req_d.is_data;
            d_err_d    = req_d.is_data & req_d.err;
         end
         default: ;
      endcase
      if (state_q == ST_DREAD) d_rdata_d = extracted;
      if (state_q == ST_FETCH) if_rdata_d = mem_dout_i;
      if (state_q == ST_IDLE && state_d == ST_DONE) d_rdata_d = '0;
   end

   // Output registers; async reset drops sram strobes mid-access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_cs_o   <= 1'b0;
         mem_oe_o   <= 1'b0;
         mem_we_o   <= 1'b0;
         mem_addr_o <= '0;
         mem_din_o  <= '0;
         d_ready_o  <= 1'b0;
         if_ready_o <= 1'b0;
         d_err_o    <= 1'b0;
         d_rdata_o  <= '0;
         if_rdata_o <= '0;
      end else begin
         mem_cs_o   <= mem_cs_d;
         mem_oe_o   <= mem_oe_d;
         mem_we_o   <= mem_we_d;
         mem_addr_o <= mem_addr_d;
         mem_din_o  <= mem_din_d;
         d_ready_o  <= d_ready_d;
         if_ready_o <= if_ready_d;
         d_err_o    <= d_err_d;
         d_rdata_o  <= d_rdata_d;
         if_rdata_o <= if_rdata_d;
      end
   end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed and random checks of dlx_mem_arbiter against a behavioural sram/load-store model.
`timescale 1ns/1ps
module tb_dlx_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [1:0]  d_size = 2'b10;
   logic        d_signed = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        d_err;
   logic        mem_cs, mem_oe, mem_we;
   logic [31:0] mem_addr, mem_din, mem_dout;

   logic [31:0] sram    [0:255];
   logic [31:0] ref_mem [0:255];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dlx_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
      .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_signed_i(d_signed),
      .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rdata_o(d_rdata), .d_ready_o(d_ready),
      .d_err_o(d_err), .mem_cs_o(mem_cs), .mem_oe_o(mem_oe), .mem_we_o(mem_we),
      .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
   );

   function automatic int widx(logic [31:0] a);
      return int'(8'(a >> 2));
   endfunction

   // sram: combinational read, synchronous write
   assign mem_dout = sram[widx(mem_addr)];
   always @(posedge clk) if (mem_cs && mem_we) sram[widx(mem_addr)] <= mem_din;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model, big-endian lanes computed arithmetically
   function automatic logic model_err(logic [1:0] sz, logic [31:0] a);
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
   endfunction

   function automatic int nbytes(logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] sz, logic [31:0] a, logic sg);
      int n, sh;
      logic [31:0] m, v;
      n  = nbytes(sz);
      sh = 8 * (4 - int'(a % 4) - n);
      m  = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      v  = (w >> sh) & m;
      if (sg && n < 4 && v[8*n-1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic [31:0] model_store(logic [31:0] w, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
      int n, sh;
      logic [31:0] m;
      n  = nbytes(sz);
      sh = 8 * (4 - int'(a % 4) - n);
      m  = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      return (w & ~(m << sh)) | ((wd & m) << sh);
   endfunction

   task automatic d_access(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int cs_n, output int we_n, output logic [31:0] din_w,
                           output logic both);
      @(negedge clk);
      d_req = 1'b1; d_we = we; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd;
      lat = 0; cs_n = 0; we_n = 0; din_w = '0; both = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (mem_cs) cs_n++;
         if (mem_we) begin we_n++; din_w = mem_din; end
         if (mem_oe && mem_we) both = 1'b1;
      end while (!d_ready && lat < 20);
      if (!d_ready) chk("d_timeout", 32'(d_ready), 32'd1);
      rd = d_rdata; er = d_err;
      d_req = 1'b0;
   endtask

   task automatic if_access(input logic [31:0] a, output int lat, output logic [31:0] rd,
                            output int we_n);
      @(negedge clk);
      if_req = 1'b1; if_addr = a;
      lat = 0; we_n = 0;
      do begin
         @(negedge clk);
         lat++;
         if (mem_we) we_n++;
      end while (!if_ready && lat < 20);
      if (!if_ready) chk("if_timeout", 32'(if_ready), 32'd1);
      rd = if_rdata;
      if_req = 1'b0;
   endtask

   logic [31:0] t2_addr [4] = '{32'h80, 32'h81, 32'h82, 32'h80};
   logic [1:0]  t2_size [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
   logic        t2_sgn  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic [31:0] t2_exp  [4] = '{32'h0000_00F0, 32'hFFFF_FFF0, 32'h0000_77F0, 32'h0000_F0F0};

   initial begin
      int lat, cs_n, we_n, dl, il, cyc;
      logic [31:0] rd, din_w, exp_v, a, wd, w;
      logic er, both, seen, we;
      logic [1:0] sz;
      logic sg;

      for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
      sram[32] <= 32'hF0F0_77F0;
      sram[4]  <= 32'h0C00_0080;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_ctl", {26'd0, mem_cs, mem_oe, mem_we, d_ready, if_ready, d_err}, 32'd0);
      chk("reset_addr", mem_addr, 32'd0);
      chk("reset_rdata", d_rdata | if_rdata | mem_din, 32'd0);
      rst_n = 1'b1;

      // 1: word load
      d_access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, lat, rd, er, cs_n, we_n, din_w, both);
      chk("t1_lat", 32'(lat), 32'd2);
      chk("t1_rdata", rd, 32'hF0F0_77F0);
      chk("t1_we_cycles", 32'(we_n), 32'd0);
      chk("t1_err", 32'(er), 32'd0);
      @(negedge clk);
      chk("t1_ready_pulse", 32'(d_ready), 32'd0);

      // 2: sub-word loads
      for (int i = 0; i < 4; i++) begin
         d_access(1'b0, t2_size[i], t2_sgn[i], t2_addr[i], 32'h0, lat, rd, er, cs_n, we_n, din_w, both);
         chk($sformatf("t2_rdata_%0d", i), rd, t2_exp[i]);
         chk($sformatf("t2_lat_%0d", i), 32'(lat), 32'd2);
      end

      // 3: byte store as RMW
      d_access(1'b1, 2'b00, 1'b0, 32'h81, 32'h0000_00AA, lat, rd, er, cs_n, we_n, din_w, both);
      chk("t3_lat", 32'(lat), 32'd3);
      chk("t3_we_cycles", 32'(we_n), 32'd1);
      chk("t3_din", din_w, 32'hF0AA_77F0);
      chk("t3_cs_cycles", 32'(cs_n), 32'd2);
      chk("t3_oe_we_overlap", 32'(both), 32'd0);
      chk("t3_sram", sram[32], 32'hF0AA_77F0);
      sram[32] <= 32'hF0F0_77F0;

      // 4: simultaneous fetch and data, data first
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 32'h80;
      if_req = 1'b1; if_addr = 32'h10;
      dl = -1; il = -1; cyc = 0;
      while (il < 0 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (d_ready) begin
            dl = cyc;
            chk("t4_d_rdata", d_rdata, 32'hF0F0_77F0);
            d_req = 1'b0;
         end
         if (if_ready) begin
            il = cyc;
            chk("t4_if_rdata", if_rdata, 32'h0C00_0080);
            if_req = 1'b0;
         end
      end
      d_req = 1'b0; if_req = 1'b0;
      chk("t4_d_lat", 32'(dl), 32'd2);
      chk("t4_if_gap", 32'(il - dl), 32'd3);

      // 5: errors
      d_access(1'b0, 2'b10, 1'b0, 32'h82, 32'h0, lat, rd, er, cs_n, we_n, din_w, both);
      chk("t5a_lat", 32'(lat), 32'd1);
      chk("t5a_err", 32'(er), 32'd1);
      chk("t5a_rdata", rd, 32'd0);
      chk("t5a_cs", 32'(cs_n), 32'd0);
      d_access(1'b0, 2'b00, 1'b0, 32'h80, 32'h0, lat, rd, er, cs_n, we_n, din_w, both);
      d_access(1'b1, 2'b11, 1'b0, 32'h80, 32'h1234, lat, rd, er, cs_n, we_n, din_w, both);
      chk("t5b_lat", 32'(lat), 32'd1);
      chk("t5b_err", 32'(er), 32'd1);
      chk("t5b_rdata", rd, 32'd0);
      chk("t5b_cs", 32'(cs_n), 32'd0);

      // 6: reset during RMW write phase
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_signed = 1'b0; d_addr = 32'h81; d_wdata = 32'hAA;
      @(negedge clk);
      chk("t6_rmw_rd", {29'd0, mem_cs, mem_oe, mem_we}, 32'b110);
      @(negedge clk);
      chk("t6_rmw_wr", {29'd0, mem_cs, mem_oe, mem_we}, 32'b101);
      rst_n = 1'b0;
      #1;
      chk("t6_strobes_drop", {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
      d_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (d_ready) seen = 1'b1;
      end
      chk("t6_no_ready", 32'(seen), 32'd0);
      chk("t6_sram", sram[32], 32'hF0F0_77F0);
      rst_n = 1'b1;
      d_access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, lat, rd, er, cs_n, we_n, din_w, both);
      chk("t6_after_lat", 32'(lat), 32'd2);
      chk("t6_after_rdata", rd, 32'hF0F0_77F0);

      // Random traffic over words 0x100..0x13C
      for (int i = 64; i < 80; i++) begin
         w = $urandom;
         sram[i] <= w;
         ref_mem[i] = w;
      end
      for (int k = 0; k < 60; k++) begin
         a = 32'h100 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 4) == 0) begin
            if_access(a, lat, rd, we_n);
            chk($sformatf("rnd%0d_if_rdata", k), rd, ref_mem[widx(a)]);
            chk($sformatf("rnd%0d_if_lat", k), 32'(lat), 32'd2);
         end else begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            wd = $urandom;
            d_access(we, sz, sg, a, wd, lat, rd, er, cs_n, we_n, din_w, both);
            chk($sformatf("rnd%0d_err", k), 32'(er), 32'(model_err(sz, a)));
            chk($sformatf("rnd%0d_overlap", k), 32'(both), 32'd0);
            if (model_err(sz, a)) begin
               chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'd1);
               chk($sformatf("rnd%0d_cs", k), 32'(cs_n), 32'd0);
            end else if (!we) begin
               exp_v = model_load(ref_mem[widx(a)], sz, a, sg);
               chk($sformatf("rnd%0d_rdata", k), rd, exp_v);
               chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'd2);
            end else begin
               ref_mem[widx(a)] = model_store(ref_mem[widx(a)], sz, a, wd);
               chk($sformatf("rnd%0d_lat", k), 32'(lat), (sz == 2'b10) ? 32'd3 - 32'd1 : 32'd3);
               chk($sformatf("rnd%0d_we_cycles", k), 32'(we_n), 32'd1);
            end
         end
      end
      @(negedge clk);
      for (int i = 64; i < 80; i++) chk($sformatf("rnd_mem_%0d", i), sram[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
